// File: rtl/chip8_pkg.sv
// Shared CHIP-8 keypad definitions: key count, scan FSM states, matrix-to-hex map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chip8_pkg;

  localparam int NUM_KEYS = 16;

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_SAMPLE = 2'd1,
    S_UPDATE = 2'd2
  } scan_state_e;

  // Matrix position {row[1:0], col[1:0]} -> hex key code; element 0 is (r0, c0).
  localparam logic [15:0][3:0] KEYPAD_MAP = {
    4'hF, 4'hB, 4'h0, 4'hA,   // row 3: cols 3..0
    4'hE, 4'h9, 4'h8, 4'h7,   // row 2
    4'hD, 4'h6, 4'h5, 4'h4,   // row 1
    4'hC, 4'h3, 4'h2, 4'h1    // row 0
  };

endpackage

// File: rtl/chip8_key_debounce.sv
// Per-key debouncer: flips key_q after DEBOUNCE_SCANS consecutive disagreeing scans.
// Latency: key_q and rose update one cycle after the update_en cycle that decides the flip.
// Backpressure: none; evaluates only on update_en, otherwise holds state.
module chip8_key_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_bit,
  input  logic update_en,
  output logic key_q,
  output logic rose
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_d;
  logic          rose_q, rose_d;

  // Debounce step: agreement clears the run, enough disagreement flips the key.
  always_comb begin
    cnt_d  = cnt_q;
    key_d  = key_q;
    rose_d = 1'b0;
    if (update_en) begin
      if (raw_bit == key_q) begin
        cnt_d = '0;
      end else if (CW'(cnt_q + CW'(1)) == CW'(DEBOUNCE_SCANS)) begin
        key_d  = ~key_q;
        cnt_d  = '0;
        rose_d = ~key_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      key_q  <= 1'b0;
      rose_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      key_q  <= key_d;
      rose_q <= rose_d;
    end
  end

  assign rose = rose_q;

endmodule

// File: rtl/chip8_keypad_scan.sv
// 4x4 hex keypad scanner: column drive, row sync, per-key debounce, new-press event.
// Latency: full scan = 4*(SCAN_DIV+1)+1 cycles; keys/press_valid update the cycle after S_UPDATE.
// Backpressure: none; free-running scan, press_valid is a single-cycle pulse with no handshake.
module chip8_keypad_scan
  import chip8_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        press_valid,
  output logic [3:0]  press_code
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  scan_state_e         state_q, state_d;
  logic [1:0]          col_q, col_d;
  logic [DW-1:0]       div_cnt_q, div_cnt_d;
  logic [3:0]          sync1_q, sync2_q;
  logic [15:0]         raw_q, raw_d;
  logic [NUM_KEYS-1:0] rose;
  logic                update_en;
  logic [3:0]          enc_code;
  logic [3:0]          press_code_q, press_code_d;

  // Two-flop synchronizer; idle (pulled-up) rows read as 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  // Scan FSM: settle on a column, sample its rows, then debounce after column 3.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    div_cnt_d = div_cnt_q;
    raw_d     = raw_q;
    col_out   = 4'hF;
    case (state_q)
      S_SETTLE: begin
        col_out = ~(4'b0001 << col_q);
        if (div_cnt_q == DW'(SCAN_DIV - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      S_SAMPLE: begin
        col_out = ~(4'b0001 << col_q);
        for (int r = 0; r < 4; r++) begin
          raw_d[KEYPAD_MAP[{2'(r), col_q}]] = ~sync2_q[r];
        end
        if (col_q == 2'd3) begin
          state_d = S_UPDATE;
        end else begin
          col_d     = col_q + 2'd1;
          div_cnt_d = '0;
          state_d   = S_SETTLE;
        end
      end
      S_UPDATE: begin
        col_d     = 2'd0;
        div_cnt_d = '0;
        state_d   = S_SETTLE;
      end
      default: begin
        state_d = S_SETTLE;
      end
    endcase
  end

  // Scan FSM and raw snapshot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_SETTLE;
      col_q     <= 2'd0;
      div_cnt_q <= '0;
      raw_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      div_cnt_q <= div_cnt_d;
      raw_q     <= raw_d;
    end
  end

  assign update_en = (state_q == S_UPDATE);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    chip8_key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw_bit  (raw_q[g]),
      .update_en(update_en),
      .key_q    (keys[g]),
      .rose     (rose[g])
    );
  end

  // Lowest-index rising key wins; code holds its last value between pulses.
  always_comb begin
    enc_code = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rose[i]) begin
        enc_code = 4'(i);
      end
    end
    press_code_d = press_valid ? enc_code : press_code_q;
  end

  // Last reported press code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_code_q <= 4'd0;
    end else begin
      press_code_q <= press_code_d;
    end
  end

  assign press_valid = |rose;
  assign press_code  = press_code_d;

endmodule

// File: doc/chip8_keypad_scan.md
Name: chip8_keypad_scan

Overview:
Upstream input stage for the CHIP-8 core. Scans a physical 4x4 hex keypad matrix by driving columns and sampling rows, debounces each key, and presents the 16-bit `keys` vector consumed by chip8_top/chip8_cpu. Also emits a one-cycle "new key pressed" event with its hex code, for the FX0A wait-for-key instruction.

Parameters:
- SCAN_DIV, 1000: settle cycles per driven column before sampling. Must be >= 3, to cover the 2-flop row synchronizer plus margin.
- DEBOUNCE_SCANS, 4: consecutive full scans a key must disagree with its debounced state before that state flips. Must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- row_in  input  4  matrix rows, active-low, externally pulled up
- col_out  output  4  matrix column drive, active-low, at most one bit low
- keys  output  16  debounced key state; bit k = 1 means hex key k is held
- press_valid  output  1  one-cycle pulse when any key goes 0->1 in `keys`
- press_code  output  4  hex code of the newly pressed key; valid while press_valid = 1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, and clears all state immediately, including mid-scan.
- Reset values:
  - col_out = 4'b1110 (column 0 driven)
  - keys = 0, press_valid = 0, press_code = 0
  - row synchronizer = 4'b1111
  - raw snapshot = 0, all debounce counters = 0
  - state = S_SETTLE, col = 0, div_cnt = 0
- Row input: row_in passes through a 2-flop synchronizer before any use.
- FSM states:
  - S_SETTLE: col_out = ~(1<<col). div_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 go to S_SAMPLE.
  - S_SAMPLE: 1 cycle. Capture the synchronized rows into raw, using the key map: position (r, col) is pressed when row_sync[r] = 0. col_out is unchanged. If col = 3 go to S_UPDATE; otherwise col++, div_cnt = 0, go to S_SETTLE.
  - S_UPDATE: 1 cycle. col_out = 4'b1111 (nothing driven). Run the debounce step, then set col = 0, div_cnt = 0, go to S_SETTLE.
- Full scan period = 4*(SCAN_DIV+1)+1 cycles.
- Key map, position (row r, col c) -> hex key:
  - r0: 1, 2, 3, C
  - r1: 4, 5, 6, D
  - r2: 7, 8, 9, E
  - r3: A, 0, B, F
- Debounce, per key k, evaluated only in S_UPDATE:
  - If raw[k] == keys[k]: cnt[k] = 0.
  - Else if cnt[k] + 1 == DEBOUNCE_SCANS: keys[k] flips and cnt[k] = 0.
  - Else: cnt[k]++.
  - Counter width is clog2(DEBOUNCE_SCANS+1).
  - The new keys value is registered at the end of S_UPDATE and is visible on the following cycle.
- Press event:
  - press_valid is asserted on the same cycle keys changes, and only if at least one bit went 0->1.
  - press_code is the lowest newly set index.
  - A release (1->0) never pulses.
  - press_valid is low on every other cycle; press_code holds its last value.
- No ghost-key rejection. Raw captures are used as sampled.

Decomposition:
- Shared package chip8_pkg holds:
  - KEYPAD_MAP: 16-entry constant, matrix position {r,c} -> 4-bit hex code
  - the FSM state enum {S_SETTLE, S_SAMPLE, S_UPDATE}
  - NUM_KEYS = 16
- One natural sub-module: chip8_key_debounce. It is per-key: counter plus state bit, with inputs raw_bit and update_en, and outputs key_q and rose. It is instantiated 16 times.
- The top-level block contains the FSM, synchronizer, column drive and priority encoder for press_code.

Test Plan:
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 2, so the scan period is 21 cycles. The bench models the matrix as row_in[r] = 0 when key (r, c) is held and col_out[c] = 0.
1. Reset and idle scan: assert reset -> col_out = 1110, keys = 0, press_valid = 0. After release, col_out goes 1110 (5 cycles), 1101 (5), 1011 (5), 0111 (5), 1111 (1), then repeats.
2. Single press: hold key 1 (r0, c0) from the first scan -> keys = 16'h0002 one cycle after the second S_UPDATE, with exactly one press_valid pulse and press_code = 1. No further pulses while held.
3. Bounce rejection: hold key 5 for exactly one scan, then release -> keys stays 16'h0000 and there are no pulses. A release glitch of one scan during a stable hold of key 5 leaves keys[5] = 1.
4. Simultaneous press: hold key 0 (r3, c1) and key F (r3, c3) together -> keys = 16'h8001 and a single pulse with press_code = 0. Adding key 9 later gives keys = 16'h8201 and a pulse with code 9.
5. Release: release all keys -> keys = 0 after 2 scans, with no press_valid pulse.
6. Reset mid-scan: with keys = 16'h8001 held, assert reset in S_SETTLE of column 2 -> keys = 0 and col_out = 1110 immediately, without waiting for a clock edge. After release, debounce restarts and keys returns to 16'h8001 after 2 scans, with a pulse of code 0.
